mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-port I2C subordinate RAM (7-bit address, 8-bit data) between the I2C memory interface (port 0) and a local host requester (port 1). It grants one access per clock, drives the RAM's address/data/write-enable, and returns read data to the winning port after a fixed, parameterised latency. It also enforces a programmable write-protect boundary so the host can lock the upper region of memory against I2C writes, or against its own writes.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing a single-port RAM between the I2C memory interface (port 0)
// and a local host (port 1), with round-robin ties, read-return tagging and write protection.
module mem_port_arbiter #(
    parameter int AW     = 7,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,

    input  logic          wp_en,
    input  logic [AW-1:0] wp_base,

    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    localparam int TAG_DEPTH = 1 + RD_LAT;

    function automatic logic is_protected(input logic          en,
                                          input logic [AW-1:0] addr,
                                          input logic [AW-1:0] base);
        return en && (addr >= base);
    endfunction

    logic [1:0]           gnt_s;
    logic                 win_s;
    logic                 sel_we_s;
    logic [AW-1:0]        sel_addr_s;
    logic [DW-1:0]        sel_wdata_s;
    logic                 prot_s;
    logic                 grant_any_s;
    logic                 wr_ok_s;
    logic                 wr_rej_s;
    logic                 rd_push_s;
    logic                 exit_vld_s;
    logic                 exit_port_s;

    logic                 last_gnt_q,  last_gnt_d;
    logic [AW-1:0]        mem_addr_q,  mem_addr_d;
    logic [DW-1:0]        mem_data_q,  mem_data_d;
    logic                 mem_wren_q,  mem_wren_d;
    logic [TAG_DEPTH-1:0] tag_vld_q,   tag_vld_d;
    logic [TAG_DEPTH-1:0] tag_port_q,  tag_port_d;
    logic [1:0]           rvalid_q,    rvalid_d;
    logic [1:0]           err_q,       err_d;
    logic [DW-1:0]        rdata0_q,    rdata0_d;
    logic [DW-1:0]        rdata1_q,    rdata1_d;

    // Arbitration: sole requester wins; on a tie the port not granted last wins.
    always_comb begin
        gnt_s = 2'b00;
        win_s = 1'b0;
        if (!rst_n) begin
            gnt_s = 2'b00;
            win_s = 1'b0;
        end else begin
            case ({p1_req, p0_req})
                2'b01: begin
                    gnt_s = 2'b01;
                    win_s = 1'b0;
                end
                2'b10: begin
                    gnt_s = 2'b10;
                    win_s = 1'b1;
                end
                2'b11: begin
                    if (last_gnt_q) begin
                        gnt_s = 2'b01;
                        win_s = 1'b0;
                    end else begin
                        gnt_s = 2'b10;
                        win_s = 1'b1;
                    end
                end
                default: begin
                    gnt_s = 2'b00;
                    win_s = 1'b0;
                end
            endcase
        end
    end

    // Request-field mux for the winning port and access classification.
    always_comb begin
        if (win_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
        prot_s      = is_protected(wp_en, sel_addr_s, wp_base);
        grant_any_s = |gnt_s;
        wr_ok_s     = grant_any_s && sel_we_s && !prot_s;
        wr_rej_s    = grant_any_s && sel_we_s && prot_s;
        rd_push_s   = grant_any_s && !sel_we_s;
        exit_vld_s  = tag_vld_q[TAG_DEPTH-1];
        exit_port_s = tag_port_q[TAG_DEPTH-1];
    end

    // Next-state for RAM drive, tag pipeline and per-port responses.
    always_comb begin
        if (grant_any_s) begin
            last_gnt_d = win_s;
            mem_addr_d = sel_addr_s;
            mem_data_d = sel_wdata_s;
        end else begin
            last_gnt_d = last_gnt_q;
            mem_addr_d = mem_addr_q;
            mem_data_d = mem_data_q;
        end
        mem_wren_d  = wr_ok_s;
        tag_vld_d   = {tag_vld_q[TAG_DEPTH-2:0], rd_push_s};
        tag_port_d  = {tag_port_q[TAG_DEPTH-2:0], win_s};
        rvalid_d[0] = exit_vld_s && !exit_port_s;
        rvalid_d[1] = exit_vld_s && exit_port_s;
        err_d[0]    = wr_rej_s && !win_s;
        err_d[1]    = wr_rej_s && win_s;
        if (rvalid_d[0]) begin
            rdata0_d = mem_q;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rvalid_d[1]) begin
            rdata1_d = mem_q;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State registers; reset discards in-flight read tags so no stale rvalid escapes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            mem_addr_q <= {AW{1'b0}};
            mem_data_q <= {DW{1'b0}};
            mem_wren_q <= 1'b0;
            tag_vld_q  <= {TAG_DEPTH{1'b0}};
            tag_port_q <= {TAG_DEPTH{1'b0}};
            rvalid_q   <= 2'b00;
            err_q      <= 2'b00;
            rdata0_q   <= {DW{1'b0}};
            rdata1_q   <= {DW{1'b0}};
        end else begin
            last_gnt_q <= last_gnt_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign p0_gnt      = gnt_s[0];
    assign p1_gnt      = gnt_s[1];
    assign p0_rvalid   = rvalid_q[0];
    assign p1_rvalid   = rvalid_q[1];
    assign p0_err      = err_q[0];
    assign p1_err      = err_q[1];
    assign p0_rdata    = rdata0_q;
    assign p1_rdata    = rdata1_q;
    assign mem_address = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle scoreboard built from the arbitration,
// protection and latency rules, plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    parameter int RD_LAT = 1;
    localparam int NC = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [6:0] p0_addr = 7'h00, p1_addr = 7'h00, wp_base = 7'h00;
    logic [7:0] p0_wdata = 8'h00, p1_wdata = 8'h00;
    logic       wp_en = 1'b0;
    logic       p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_wren;
    logic [7:0] p0_rdata, p1_rdata, mem_data, mem_q;
    logic [6:0] mem_address;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_port_arbiter #(.AW(7), .DW(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .wp_en(wp_en), .wp_base(wp_base),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with RD_LAT clocks from registered address to read data.
    logic [7:0] ram [0:127];
    logic [7:0] qp  [0:RD_LAT-1];
    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 8'h00;
        for (int i = 0; i < RD_LAT; i++) qp[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_wren === 1'b1) ram[mem_address] <= mem_data;
        qp[0] <= ram[mem_address];
        for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
    end
    assign mem_q = qp[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard: memory image updated in grant order, expected events indexed by cycle.
    logic [7:0] m_mem [0:127];
    bit         exp_rv  [0:1][0:NC-1];
    logic [7:0] exp_rd  [0:1][0:NC-1];
    bit         exp_err [0:1][0:NC-1];
    bit         exp_wren [0:NC-1];
    bit         exp_upd  [0:NC-1];
    logic [6:0] exp_a    [0:NC-1];
    logic [7:0] exp_d    [0:NC-1];
    logic [7:0] m_hold [0:1];
    logic [6:0] m_ah;
    logic [7:0] m_dh;
    bit         m_last = 1'b1;
    bit         armed  = 1'b0;

    initial for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;

    always @(negedge clk) begin
        logic [1:0] eg;
        logic       w, we, prot;
        logic [6:0] a;
        logic [7:0] d;
        eg = 2'b00;
        if (armed) begin
            if (rst_n) begin
                if (p0_req && p1_req) eg = m_last ? 2'b01 : 2'b10;
                else                  eg = {p1_req, p0_req};
            end
            chk("gnt0", {31'd0, p0_gnt}, {31'd0, eg[0]});
            chk("gnt1", {31'd0, p1_gnt}, {31'd0, eg[1]});
            if (exp_rv[0][cyc]) m_hold[0] = exp_rd[0][cyc];
            if (exp_rv[1][cyc]) m_hold[1] = exp_rd[1][cyc];
            chk("rvalid0", {31'd0, p0_rvalid}, {31'd0, exp_rv[0][cyc]});
            chk("rvalid1", {31'd0, p1_rvalid}, {31'd0, exp_rv[1][cyc]});
            chk("rdata0", {24'd0, p0_rdata}, {24'd0, m_hold[0]});
            chk("rdata1", {24'd0, p1_rdata}, {24'd0, m_hold[1]});
            chk("err0", {31'd0, p0_err}, {31'd0, exp_err[0][cyc]});
            chk("err1", {31'd0, p1_err}, {31'd0, exp_err[1][cyc]});
            chk("wren", {31'd0, mem_wren}, {31'd0, exp_wren[cyc]});
            if (exp_upd[cyc]) begin
                m_ah = exp_a[cyc];
                m_dh = exp_d[cyc];
            end
            chk("mem_addr", {25'd0, mem_address}, {25'd0, m_ah});
            chk("mem_data", {24'd0, mem_data}, {24'd0, m_dh});
        end
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                exp_rv[0][i] = 1'b0;  exp_rv[1][i] = 1'b0;
                exp_err[0][i] = 1'b0; exp_err[1][i] = 1'b0;
                exp_wren[i] = 1'b0;   exp_upd[i] = 1'b0;
            end
            m_hold[0] = 8'h00;
            m_hold[1] = 8'h00;
            m_ah   = 7'h00;
            m_dh   = 8'h00;
            m_last = 1'b1;
            armed  = 1'b1;
        end else if (armed && eg != 2'b00) begin
            w  = eg[1];
            we = w ? p1_we : p0_we;
            a  = w ? p1_addr : p0_addr;
            d  = w ? p1_wdata : p0_wdata;
            prot = wp_en && (a >= wp_base);
            exp_upd[cyc+1] = 1'b1;
            exp_a[cyc+1]   = a;
            exp_d[cyc+1]   = d;
            if (we) begin
                if (prot) begin
                    exp_err[w][cyc+1] = 1'b1;
                end else begin
                    exp_wren[cyc+1] = 1'b1;
                    m_mem[a] = d;
                end
            end else begin
                exp_rv[w][cyc+2+RD_LAT] = 1'b1;
                exp_rd[w][cyc+2+RD_LAT] = m_mem[a];
            end
            m_last = w;
        end
    end

    // Raise req on one port and hold it until granted (bounded), then drop it.
    task automatic access(input int port, input logic we, input logic [6:0] addr,
                          input logic [7:0] wdata, input string nm);
        logic g;
        g = 1'b0;
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g = (port == 0) ? p0_gnt : p1_gnt;
            if (g === 1'b1) break;
            @(posedge clk); #1;
        end
        chk(nm, {31'd0, g}, 32'd1);
        @(posedge clk); #1;
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        logic g0;
        step(3);
        @(negedge clk);
        chk("rst_rdata0", {24'd0, p0_rdata}, 32'h0);
        chk("rst_wren", {31'd0, mem_wren}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);

        // Host write then I2C read of the same location.
        access(1, 1'b1, 7'h10, 8'hA5, "pre_gnt1");
        @(negedge clk);
        chk("pre_wren", {31'd0, mem_wren}, 32'd1);
        chk("pre_addr", {25'd0, mem_address}, 32'h10);
        chk("pre_data", {24'd0, mem_data}, 32'hA5);
        @(posedge clk); #1;
        access(0, 1'b0, 7'h10, 8'h00, "rd_gnt0");
        repeat (1 + RD_LAT) @(posedge clk);
        @(negedge clk);
        chk("rd_rvalid0", {31'd0, p0_rvalid}, 32'd1);
        chk("rd_rdata0", {24'd0, p0_rdata}, 32'hA5);
        step(1);

        // Contention: both ports read continuously, addresses 0..5.
        for (int i = 0; i < 6; i++) access(1, 1'b1, i[6:0], 8'h30 + i[7:0], "fill");
        step(2);
        n0 = 0; n1 = 0;
        p0_we = 1'b0; p0_addr = 7'd0; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 7'd1; p1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g0 = p0_gnt;
            chk("rr_gnt0", {31'd0, p0_gnt}, {31'd0, (i % 2 == 0)});
            chk("rr_gnt1", {31'd0, p1_gnt}, {31'd0, (i % 2 == 1)});
            @(posedge clk); #1;
            if (g0) begin
                n0++; p0_addr = 7'(2 * n0);
                if (n0 >= 3) p0_req = 1'b0;
            end else begin
                n1++; p1_addr = 7'(2 * n1 + 1);
                if (n1 >= 3) p1_req = 1'b0;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step(RD_LAT + 4);
        chk("rr_last0", {24'd0, p0_rdata}, 32'h34);
        chk("rr_last1", {24'd0, p1_rdata}, 32'h35);

        // Write protection.
        access(0, 1'b1, 7'h40, 8'h77, "wp_pre");
        wp_en = 1'b1; wp_base = 7'h40;
        access(0, 1'b1, 7'h40, 8'h55, "wp_gnt");
        @(negedge clk);
        chk("wp_wren_blk", {31'd0, mem_wren}, 32'd0);
        chk("wp_err0", {31'd0, p0_err}, 32'd1);
        @(posedge clk); #1;
        access(0, 1'b1, 7'h3F, 8'h66, "wp_ok_gnt");
        @(negedge clk);
        chk("wp_wren_ok", {31'd0, mem_wren}, 32'd1);
        chk("wp_noerr", {31'd0, p0_err}, 32'd0);
        @(posedge clk); #1;
        access(1, 1'b0, 7'h40, 8'h00, "wp_rd_gnt");
        repeat (1 + RD_LAT) @(posedge clk);
        @(negedge clk);
        chk("wp_rd_old", {24'd0, p1_rdata}, 32'h77);
        @(posedge clk); #1;
        wp_base = 7'h00;
        access(1, 1'b1, 7'h00, 8'h99, "wp0_gnt");
        @(negedge clk);
        chk("wp0_err1", {31'd0, p1_err}, 32'd1);
        chk("wp0_wren", {31'd0, mem_wren}, 32'd0);
        @(posedge clk); #1;
        wp_en = 1'b0;

        // Write then immediate read from the other port.
        access(0, 1'b1, 7'h20, 8'h11, "raw_wr");
        access(1, 1'b0, 7'h20, 8'h00, "raw_rd");
        repeat (1 + RD_LAT) @(posedge clk);
        @(negedge clk);
        chk("raw_rvalid", {31'd0, p1_rvalid}, 32'd1);
        chk("raw_data", {24'd0, p1_rdata}, 32'h11);
        step(3);

        // Reset with reads in flight.
        p0_we = 1'b0; p0_addr = 7'h10; p0_req = 1'b1;
        @(negedge clk);
        chk("inf_gnt0", {31'd0, p0_gnt}, 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_we = 1'b0; p1_addr = 7'h20; p1_req = 1'b1;
        @(negedge clk);
        chk("inf_gnt1", {31'd0, p1_gnt}, 32'd1);
        @(posedge clk); #1;
        p1_req = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("rst_rd0_zero", {24'd0, p0_rdata}, 32'h0);
        chk("rst_rd1_zero", {24'd0, p1_rdata}, 32'h0);
        chk("rst_addr_zero", {25'd0, mem_address}, 32'h0);
        for (int i = 0; i < RD_LAT + 3; i++) begin
            chk("no_rvalid0", {31'd0, p0_rvalid}, 32'd0);
            chk("no_rvalid1", {31'd0, p1_rvalid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        p0_we = 1'b0; p0_addr = 7'h00; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 7'h01; p1_req = 1'b1;
        @(negedge clk);
        chk("tie_p0", {31'd0, p0_gnt}, 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        @(negedge clk);
        chk("tie_p1", {31'd0, p1_gnt}, 32'd1);
        @(posedge clk); #1;
        p1_req = 1'b0;
        step(RD_LAT + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
